sdram_resp: RTL and testbench

// Synthesizable SDRAM device responder: the device end of the SDRAM command bus our controller drives.

---
 rtl/sdram_resp.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sdram_resp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_resp.sv
// ----------------------------------------------------------------------------
// sdram_resp
// Device end of the SDRAM command bus. Decodes commands, tracks the mode
// register and per-bank open rows, stores write bursts in an on-chip array,
// returns read bursts at CAS latency and flags the first protocol violation.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   sdram_cke/cs_n/ras_n/
//   cas_n/we_n               command bus
//   sdram_ba, sdram_addr     bank, row/column/mode bits (addr[10] = all banks on PRE)
//   sdram_dqm                write byte mask, 1 = byte not written
//   dq_i                     write data
//   dq_o, dq_oe              read data and its drive enable
//   mode_valid               a mode register load has been accepted
//   cas_lat, burst_len       latched CL and decoded burst length
//   err, err_code            sticky error flag and code of the first error
// ----------------------------------------------------------------------------
module sdram_resp #(
  parameter int DW       = 16,
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 9,
  parameter int T_RCD    = 2,
  parameter int T_RP     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sdram_cke,
  input  logic          sdram_cs_n,
  input  logic          sdram_ras_n,
  input  logic          sdram_cas_n,
  input  logic          sdram_we_n,
  input  logic [1:0]    sdram_ba,
  input  logic [12:0]   sdram_addr,
  input  logic [1:0]    sdram_dqm,
  input  logic [DW-1:0] dq_i,
  output logic [DW-1:0] dq_o,
  output logic          dq_oe,
  output logic          mode_valid,
  output logic [2:0]    cas_lat,
  output logic [9:0]    burst_len,
  output logic          err,
  output logic [2:0]    err_code
);

  localparam int NB   = DW / 8;
  localparam int AW   = 2 + ROW_BITS + COL_BITS;
  localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_BST, CMD_PRE, CMD_AREF, CMD_LMR
  } cmd_e;

  cmd_e                cmd;
  logic [3:0]          bank_open;
  logic [ROW_BITS-1:0] bank_row [4];
  logic [TW-1:0]       rcd_cnt  [4];
  logic [TW-1:0]       rp_cnt   [4];
  logic                full_page;
  logic [DW-1:0]       mem [2**AW];

  logic                burst_active, burst_rd;
  logic [1:0]          burst_ba;
  logic [ROW_BITS-1:0] burst_row;
  logic [COL_BITS-1:0] burst_col;
  logic [9:0]          burst_left;     // beats still to come after the current one

  logic                s1_v, s2_v;
  logic [DW-1:0]       s1_d, s2_d;

  logic [9:0]          lmr_bl;
  logic                lmr_page, lmr_bad;
  logic [2:0]          cmd_err;
  logic                cmd_ok;
  logic                rd_start, wr_start, rw_start, pre_hits, stop_burst;
  logic                cont_rd, cont_wr, rd_en, wr_en;
  logic [AW-1:0]       new_idx, cur_idx, rd_idx, wr_idx;
  logic [DW-1:0]       rd_data;

  // Only a few address bits matter for each command.
  logic unused_addr;
  assign unused_addr = ^sdram_addr;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cmd = CMD_NOP;
    if (sdram_cke && !sdram_cs_n) begin
      case ({sdram_ras_n, sdram_cas_n, sdram_we_n})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_READ;
        3'b100:  cmd = CMD_WRITE;
        3'b110:  cmd = CMD_BST;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_AREF;
        3'b000:  cmd = CMD_LMR;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  always_comb begin
    lmr_bl   = 10'd0;
    lmr_page = 1'b0;
    lmr_bad  = 1'b0;
    case (sdram_addr[2:0])
      3'b000:  lmr_bl = 10'd1;
      3'b001:  lmr_bl = 10'd2;
      3'b010:  lmr_bl = 10'd4;
      3'b011:  lmr_bl = 10'd8;
      3'b111:  begin lmr_bl = 10'(2**COL_BITS); lmr_page = 1'b1; end
      default: lmr_bad = 1'b1;
    endcase
    if (sdram_addr[6:4] != 3'd2 && sdram_addr[6:4] != 3'd3) lmr_bad = 1'b1;
  end

  // Error checks in priority order; a non-zero code cancels the command.
  always_comb begin
    cmd_err = 3'd0;
    case (cmd)
      CMD_ACT: begin
        if (!mode_valid)                cmd_err = 3'd1;
        else if (bank_open[sdram_ba])   cmd_err = 3'd2;
        else if (rp_cnt[sdram_ba] != '0) cmd_err = 3'd7;
      end
      CMD_READ, CMD_WRITE: begin
        if (!mode_valid)                 cmd_err = 3'd1;
        else if (!bank_open[sdram_ba])   cmd_err = 3'd3;
        else if (rcd_cnt[sdram_ba] != '0) cmd_err = 3'd4;
      end
      CMD_AREF: if (|bank_open) cmd_err = 3'd5;
      CMD_LMR: begin
        if (|bank_open)  cmd_err = 3'd5;
        else if (lmr_bad) cmd_err = 3'd6;
      end
      default: ;
    endcase
  end

  assign cmd_ok     = (cmd_err == 3'd0);
  assign rd_start   = (cmd == CMD_READ)  && cmd_ok;
  assign wr_start   = (cmd == CMD_WRITE) && cmd_ok;
  assign rw_start   = rd_start || wr_start;
  assign pre_hits   = (cmd == CMD_PRE) && (sdram_addr[10] || sdram_ba == burst_ba);
  assign stop_burst = rw_start || pre_hits || (cmd == CMD_BST);

  // A write burst interrupted by READ still stores its beat on that edge;
  // every other interruption drops the old beat.
  assign cont_rd = sdram_cke && burst_active && burst_rd && !stop_burst;
  assign cont_wr = sdram_cke && burst_active && !burst_rd && (!stop_burst || rd_start);

  assign new_idx = {sdram_ba, bank_row[sdram_ba], sdram_addr[COL_BITS-1:0]};
  assign cur_idx = {burst_ba, burst_row, burst_col};
  assign wr_en   = wr_start || cont_wr;
  assign wr_idx  = wr_start ? new_idx : cur_idx;
  assign rd_en   = rd_start || cont_rd;
  assign rd_idx  = rd_start ? new_idx : cur_idx;

  // Same-edge write beat is visible to the read (write-first).
  always_comb begin
    rd_data = mem[rd_idx];
    if (wr_en && wr_idx == rd_idx) begin
      for (int b = 0; b < NB; b++)
        if (!sdram_dqm[b]) rd_data[8*b +: 8] = dq_i[8*b +: 8];
    end
  end

  // NOTE: the storage array is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int b = 0; b < NB; b++)
        if (!sdram_dqm[b]) mem[wr_idx][8*b +: 8] <= dq_i[8*b +: 8];
    end
  end

  // Burst engine: holds while cke is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_active <= 1'b0;
      burst_rd     <= 1'b0;
      burst_ba     <= '0;
      burst_row    <= '0;
      burst_col    <= '0;
      burst_left   <= '0;
    end else if (sdram_cke) begin
      if (rw_start) begin
        burst_active <= full_page || (burst_len > 10'd1);
        burst_rd     <= rd_start;
        burst_ba     <= sdram_ba;
        burst_row    <= bank_row[sdram_ba];
        burst_col    <= sdram_addr[COL_BITS-1:0] + COL_BITS'(1);
        burst_left   <= burst_len - 10'd1;
      end else if (stop_burst) begin
        burst_active <= 1'b0;
      end else if (burst_active) begin
        burst_col  <= burst_col + COL_BITS'(1);   // wraps within the page
        burst_left <= burst_left - 10'd1;
        if (!full_page && burst_left == 10'd1) burst_active <= 1'b0;
      end
    end
  end

  // Read pipeline: a beat looked up at edge j reaches dq_o at edge j+CL-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      s1_d  <= '0;
      s2_d  <= '0;
      dq_o  <= '0;
      dq_oe <= 1'b0;
    end else if (sdram_cke) begin
      s1_v <= rd_en;
      s1_d <= rd_data;
      s2_v <= s1_v;
      s2_d <= s1_d;
      if (cas_lat == 3'd3) begin
        dq_oe <= s2_v;
        dq_o  <= s2_v ? s2_d : '0;
      end else begin
        dq_oe <= s1_v;
        dq_o  <= s1_v ? s1_d : '0;
      end
    end
  end

  // Mode register, bank state, timing counters and error latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_open  <= '0;
      mode_valid <= 1'b0;
      cas_lat    <= '0;
      burst_len  <= '0;
      full_page  <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      for (int b = 0; b < 4; b++) begin
        bank_row[b] <= '0;
        rcd_cnt[b]  <= '0;
        rp_cnt[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (rcd_cnt[b] != '0) rcd_cnt[b] <= rcd_cnt[b] - TW'(1);
        if (rp_cnt[b]  != '0) rp_cnt[b]  <= rp_cnt[b]  - TW'(1);
      end
      case (cmd)
        CMD_ACT: if (cmd_ok) begin
          bank_open[sdram_ba] <= 1'b1;
          bank_row[sdram_ba]  <= sdram_addr[ROW_BITS-1:0];
          rcd_cnt[sdram_ba]   <= TW'(T_RCD - 1);
        end
        CMD_PRE: begin
          for (int b = 0; b < 4; b++) begin
            if (sdram_addr[10] || sdram_ba == 2'(b)) begin
              bank_open[b] <= 1'b0;
              rp_cnt[b]    <= TW'(T_RP - 1);
            end
          end
        end
        CMD_LMR: if (cmd_ok) begin
          mode_valid <= 1'b1;
          cas_lat    <= sdram_addr[6:4];
          burst_len  <= lmr_bl;
          full_page  <= lmr_page;
        end
        default: ;
      endcase
      if (!cmd_ok && !err) begin
        err      <= 1'b1;
        err_code <= cmd_err;
      end
    end
  end

endmodule

// File: tb/tb_sdram_resp.sv
// ----------------------------------------------------------------------------
// tb_sdram_resp
// Directed bench for sdram_resp: table-driven command/expected-output vectors
// plus hand-written sequences for errors and reset.
// ----------------------------------------------------------------------------
module tb_sdram_resp;

  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101,
                         C_WR  = 3'b100, C_BST = 3'b110, C_PRE = 3'b010,
                         C_REF = 3'b001, C_LMR = 3'b000;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_dqm;
  logic [15:0] dq_i;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic        mode_valid;
  logic [2:0]  cas_lat;
  logic [9:0]  burst_len;
  logic        err;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  sdram_resp dut (
    .clk        (clk),
    .rst        (rst),
    .sdram_cke  (sdram_cke),
    .sdram_cs_n (sdram_cs_n),
    .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n),
    .sdram_we_n (sdram_we_n),
    .sdram_ba   (sdram_ba),
    .sdram_addr (sdram_addr),
    .sdram_dqm  (sdram_dqm),
    .dq_i       (dq_i),
    .dq_o       (dq_o),
    .dq_oe      (dq_oe),
    .mode_valid (mode_valid),
    .cas_lat    (cas_lat),
    .burst_len  (burst_len),
    .err        (err),
    .err_code   (err_code)
  );

  typedef struct {
    logic [2:0]  c;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dqm;
    logic [15:0] dq;
    logic        exp_oe;
    logic [15:0] exp_dq;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Apply one command for one edge; returns #1 after that edge.
  task automatic drive(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] addr,
                       input logic [1:0] dqm, input logic [15:0] dq);
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
    sdram_ba   = ba;
    sdram_addr = addr;
    sdram_dqm  = dqm;
    dq_i       = dq;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop();
    nop();
    rst = 1'b0;
  endtask

  function automatic void v(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] addr,
                            input logic [1:0] dqm, input logic [15:0] dq,
                            input logic oe, input logic [15:0] edq);
    vecs.push_back('{c, ba, addr, dqm, dq, oe, edq});
  endfunction

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].c, vecs[i].ba, vecs[i].addr, vecs[i].dqm, vecs[i].dq);
      check($sformatf("%s[%0d].oe", tag, i), dq_oe, vecs[i].exp_oe);
      if (vecs[i].exp_oe) check($sformatf("%s[%0d].dq", tag, i), dq_o, vecs[i].exp_dq);
    end
    vecs.delete();
  endtask

  task automatic run_err(input string name, input logic [12:0] lmr,
                         input logic [2:0] c1, input logic [2:0] c2, input logic [2:0] code);
    do_reset();
    drive(C_LMR, 2'd0, lmr, 2'b00, 16'h0);
    drive(c1, 2'd0, 13'd0, 2'b00, 16'h0);
    drive(c2, 2'd0, 13'd0, 2'b00, 16'h0);
    check({name, ".err"}, err, 1'b1);
    check({name, ".code"}, err_code, code);
  endtask

  initial begin
    sdram_cke  = 1'b1;
    sdram_cs_n = 1'b0;
    rst        = 1'b0;
    do_reset();
    check("rst.oe", dq_oe, 1'b0);
    check("rst.dq", dq_o, 16'h0);
    check("rst.mode_valid", mode_valid, 1'b0);
    check("rst.cas_lat", cas_lat, 3'd0);
    check("rst.burst_len", burst_len, 10'd0);
    check("rst.err", err, 1'b0);

    drive(C_LMR, 2'd0, 13'h033, 2'b00, 16'h0);
    check("lmr33.mode_valid", mode_valid, 1'b1);
    check("lmr33.cas_lat", cas_lat, 3'd3);
    check("lmr33.burst_len", burst_len, 10'd8);
    check("lmr33.err", err, 1'b0);

    // BL8 write then read, CL3.
    v(C_ACT, 2'd1, 13'h002, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_WR,  2'd1, 13'h010, 2'b00, 16'h1000, 1'b0, 16'h0);
    for (int i = 1; i < 8; i++)
      v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h1000 + 16'(i), 1'b0, 16'h0);
    v(C_RD,  2'd1, 13'h010, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++)
      v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'h1000 + 16'(i));
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_LMR, 2'd0, 13'h037, 2'b00, 16'h0, 1'b0, 16'h0);
    run_vecs("bl8");
    check("lmr37.burst_len", burst_len, 10'd512);
    check("lmr37.cas_lat", cas_lat, 3'd3);

    // Full page with wrap at 0x1FF and BST termination.
    v(C_ACT, 2'd1, 13'h002, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_WR,  2'd1, 13'h1FE, 2'b00, 16'hAAA1, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'hBBB2, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'hCCC3, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'hDDD4, 1'b0, 16'h0);
    v(C_BST, 2'd0, 13'h000, 2'b00, 16'hEEEE, 1'b0, 16'h0);
    v(C_RD,  2'd1, 13'h1FE, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'hAAA1);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'hBBB2);
    v(C_BST, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'hCCC3);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'hDDD4);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    // Byte mask: upper byte kept, lower byte replaced.
    v(C_WR,  2'd1, 13'h020, 2'b00, 16'h1234, 1'b0, 16'h0);
    v(C_BST, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_WR,  2'd1, 13'h020, 2'b10, 16'hABCD, 1'b0, 16'h0);
    v(C_BST, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_RD,  2'd1, 13'h020, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_BST, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'h12CD);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    run_vecs("page");

    // Read to an idle bank, then a too-early ACT must not overwrite the code.
    drive(C_RD, 2'd2, 13'h010, 2'b00, 16'h0);
    check("idle_rd.err", err, 1'b1);
    check("idle_rd.code", err_code, 3'd3);
    for (int i = 0; i < 4; i++) begin
      nop();
      check($sformatf("idle_rd.oe%0d", i), dq_oe, 1'b0);
    end
    drive(C_PRE, 2'd0, 13'h000, 2'b00, 16'h0);
    drive(C_ACT, 2'd0, 13'h001, 2'b00, 16'h0);
    check("early_act.code", err_code, 3'd3);

    // Reset in the middle of a page read.
    drive(C_RD, 2'd1, 13'h010, 2'b00, 16'h0);
    nop();
    nop();
    check("mid.oe", dq_oe, 1'b1);
    check("mid.dq", dq_o, 16'h1000);
    rst = 1'b1;
    nop();
    check("mid_rst.oe", dq_oe, 1'b0);
    check("mid_rst.mode_valid", mode_valid, 1'b0);
    check("mid_rst.err", err, 1'b0);
    check("mid_rst.burst_len", burst_len, 10'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nop();
      check($sformatf("post_rst.oe%0d", i), dq_oe, 1'b0);
    end
    drive(C_RD, 2'd1, 13'h010, 2'b00, 16'h0);
    check("rd_no_mode.code", err_code, 3'd1);

    // Remaining error codes, each from a fresh reset.
    run_err("trcd", 13'h033, C_ACT, C_RD,  3'd4);
    run_err("bad_cl", 13'h053, C_NOP, C_NOP, 3'd6);
    check("bad_cl.mode_valid", mode_valid, 1'b0);
    run_err("act_open", 13'h023, C_ACT, C_ACT, 3'd2);
    check("act_open.cas_lat", cas_lat, 3'd2);
    run_err("aref_open", 13'h022, C_ACT, C_REF, 3'd5);
    check("aref_open.burst_len", burst_len, 10'd4);
    run_err("trp", 13'h033, C_PRE, C_ACT, 3'd7);

    // CL2, BL2: latency and burst bound.
    do_reset();
    drive(C_LMR, 2'd0, 13'h021, 2'b00, 16'h0);
    check("lmr21.cas_lat", cas_lat, 3'd2);
    check("lmr21.burst_len", burst_len, 10'd2);
    v(C_ACT, 2'd3, 13'h001, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_WR,  2'd3, 13'h005, 2'b00, 16'h5555, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h6666, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h7777, 1'b0, 16'h0);
    v(C_RD,  2'd3, 13'h005, 2'b00, 16'h0, 1'b0, 16'h0);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'h5555);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b1, 16'h6666);
    v(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, 1'b0, 16'h0);
    run_vecs("cl2");
    check("cl2.err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
